// File: rtl/lifo_stack_pkg.sv
// rtl/lifo_stack_pkg.sv - shared defaults and {push, pop} op encoding for lifo_stack
package lifo_stack_pkg;

  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_DEPTH  = 16;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_SWAP = 2'b11
  } op_e;

  function automatic op_e decode_op(input logic push, input logic pop);
    return op_e'({push, pop});
  endfunction

endpackage

// File: rtl/lifo_stack_mem.sv
// rtl/lifo_stack_mem.sv - stack storage: one synchronous write port, one asynchronous read port
module lifo_stack_mem
  import lifo_stack_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lifo_stack.sv
// rtl/lifo_stack.sv - LIFO stack top: op decode, occupancy count, status flags, registered pop output
// Build option: LIFO_STACK_STICKY_ERR_EN makes overflow/underflow sticky until reset.
module lifo_stack
  import lifo_stack_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int DEPTH   = DEFAULT_DEPTH,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              pop_valid,
  output logic [DATA_W-1:0] top,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);

  op_e               op;
  logic [AW-1:0]     top_idx;
  logic [AW-1:0]     wr_idx;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] dout_nxt;
  logic              wr_en;
  logic              cnt_inc;
  logic              cnt_dec;
  logic              pv_nxt;
  logic              ovf_ev;
  logic              udf_ev;

  assign op    = decode_op(push, pop);
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // At count == DEPTH the low bits are zero, so the wrap lands on DEPTH-1 as intended.
  assign top_idx = count[AW-1:0] - AW'(1);
  assign top     = empty ? '0 : rd_data;

  always_comb begin
    wr_en    = 1'b0;
    wr_idx   = top_idx;
    cnt_inc  = 1'b0;
    cnt_dec  = 1'b0;
    pv_nxt   = 1'b0;
    dout_nxt = rd_data;
    ovf_ev   = 1'b0;
    udf_ev   = 1'b0;
    case (op)
      OP_PUSH: begin
        if (full) begin
          ovf_ev = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_idx  = count[AW-1:0];
          cnt_inc = 1'b1;
        end
      end
      OP_POP: begin
        if (empty) begin
          udf_ev = 1'b1;
        end else begin
          cnt_dec = 1'b1;
          pv_nxt  = 1'b1;
        end
      end
      OP_SWAP: begin
        // Empty swap bypasses storage entirely: the pushed word comes straight back out.
        pv_nxt = 1'b1;
        if (empty) begin
          dout_nxt = data_in;
        end else begin
          wr_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

  lifo_stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en & ~reset),
    .waddr (wr_idx),
    .wdata (data_in),
    .raddr (top_idx),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      data_out  <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      pop_valid <= pv_nxt;
      if (pv_nxt) begin
        data_out <= dout_nxt;
      end
      if (cnt_inc) begin
        count <= count + CNT_W'(1);
      end else if (cnt_dec) begin
        count <= count - CNT_W'(1);
      end
`ifdef LIFO_STACK_STICKY_ERR_EN
      overflow  <= overflow | ovf_ev;
      underflow <= underflow | udf_ev;
`else
      overflow  <= ovf_ev;
      underflow <= udf_ev;
`endif
    end
  end

endmodule

// File: tb/tb_lifo_stack.sv
// tb/tb_lifo_stack.sv - self-checking bench for lifo_stack (DATA_W=8, DEPTH=4; honours LIFO_STACK_STICKY_ERR_EN)
module tb_lifo_stack;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic              pop_valid;
  logic [DATA_W-1:0] top;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic              underflow;

  lifo_stack #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .data_in   (data_in),
    .data_out  (data_out),
    .pop_valid (pop_valid),
    .top       (top),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              v;
    logic [DATA_W-1:0] d;
  } exp_t;

  exp_t              exp_q[$];
  exp_t              mon_e;
  int                n_checks = 0;
  int                n_fail = 0;

  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_cnt = 0;
  logic [DATA_W-1:0] m_dout = '0;
  logic              m_ovf = 1'b0;
  logic              m_udf = 1'b0;

`ifdef LIFO_STACK_STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  function automatic logic [DATA_W-1:0] m_top();
    return (m_cnt == 0) ? '0 : m_mem[m_cnt-1];
  endfunction

  // One cycle of stimulus; the behavioural model predicts the result and queues the pop expectation.
  task automatic do_op(input logic r, input logic p, input logic q, input logic [DATA_W-1:0] d);
    exp_t e;
    logic ovf_ev = 1'b0;
    logic udf_ev = 1'b0;
    reset = r; push = p; pop = q; data_in = d;
    e.v = 1'b0;
    if (r) begin
      m_cnt = 0; m_dout = '0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      case ({p, q})
        2'b10: if (m_cnt == DEPTH) ovf_ev = 1'b1;
               else begin m_mem[m_cnt] = d; m_cnt++; end
        2'b01: if (m_cnt == 0) udf_ev = 1'b1;
               else begin m_cnt--; m_dout = m_mem[m_cnt]; e.v = 1'b1; end
        2'b11: begin
          e.v = 1'b1;
          if (m_cnt == 0) m_dout = d;
          else begin m_dout = m_mem[m_cnt-1]; m_mem[m_cnt-1] = d; end
        end
        default: ;
      endcase
      m_ovf = STICKY ? (m_ovf | ovf_ev) : ovf_ev;
      m_udf = STICKY ? (m_udf | udf_ev) : udf_ev;
    end
    e.d = m_dout;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    reset = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (pop_valid !== mon_e.v || data_out !== mon_e.d) begin
        n_fail++;
        $display("FAIL scoreboard_pop: pop_valid=%0b data_out=%h, expected pop_valid=%0b data_out=%h",
                 pop_valid, data_out, mon_e.v, mon_e.d);
      end
    end
  end

  task automatic test_reset();
    do_op(1'b1, 1'b0, 1'b0, '0);
    do_op(1'b1, 1'b0, 1'b0, '0);
    n_checks++;
    if ({data_out, pop_valid, count, empty, full, overflow, underflow, top} !==
        {8'h00, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_state: dout=%h pv=%b cnt=%0d empty=%b full=%b ovf=%b udf=%b top=%h, expected 00 0 0 1 0 0 0 00",
               data_out, pop_valid, count, empty, full, overflow, underflow, top);
    end
  endtask

  task automatic test_push_fill();
    logic [DATA_W-1:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, 1'b1, 1'b0, vals[i]);
      n_checks++;
      if (count !== CNT_W'(i + 1) || top !== vals[i] || full !== (i == 3) || overflow !== 1'b0) begin
        n_fail++;
        $display("FAIL push_fill[%0d]: cnt=%0d top=%h full=%b ovf=%b, expected cnt=%0d top=%h full=%b ovf=0",
                 i, count, top, full, overflow, i + 1, vals[i], (i == 3));
      end
    end
  endtask

  task automatic test_overflow_drain();
    logic [DATA_W-1:0] exp_pop [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
    do_op(1'b0, 1'b1, 1'b0, 8'h55);
    n_checks++;
    if (overflow !== 1'b1 || count !== 3'd4 || top !== 8'h44 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: ovf=%b cnt=%0d top=%h full=%b, expected ovf=1 cnt=4 top=44 full=1",
               overflow, count, top, full);
    end
    for (int i = 0; i < 4; i++) begin
      do_op(1'b0, 1'b0, 1'b1, '0);
      n_checks++;
      if (data_out !== exp_pop[i] || pop_valid !== 1'b1 || overflow !== STICKY) begin
        n_fail++;
        $display("FAIL drain[%0d]: dout=%h pv=%b ovf=%b, expected dout=%h pv=1 ovf=%b",
                 i, data_out, pop_valid, overflow, exp_pop[i], STICKY);
      end
    end
    n_checks++;
    if (empty !== 1'b1 || count !== 3'd0 || top !== 8'h00) begin
      n_fail++;
      $display("FAIL drain_empty: empty=%b cnt=%0d top=%h, expected 1 0 00", empty, count, top);
    end
  endtask

  task automatic test_underflow();
    do_op(1'b0, 1'b0, 1'b1, '0);
    n_checks++;
    if (underflow !== 1'b1 || pop_valid !== 1'b0 || data_out !== 8'h11 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL underflow: udf=%b pv=%b dout=%h cnt=%0d, expected 1 0 11 0",
               underflow, pop_valid, data_out, count);
    end
    do_op(1'b0, 1'b0, 1'b0, '0);
    n_checks++;
    if (underflow !== STICKY || count !== 3'd0) begin
      n_fail++;
      $display("FAIL underflow_after: udf=%b cnt=%0d, expected udf=%b cnt=0", underflow, count, STICKY);
    end
  endtask

  task automatic test_swap();
    do_op(1'b1, 1'b0, 1'b0, '0);
    do_op(1'b0, 1'b1, 1'b0, 8'h11);
    do_op(1'b0, 1'b1, 1'b0, 8'h22);
    do_op(1'b0, 1'b1, 1'b1, 8'hAA);
    n_checks++;
    if (data_out !== 8'h22 || pop_valid !== 1'b1 || top !== 8'hAA || count !== 3'd2) begin
      n_fail++;
      $display("FAIL swap: dout=%h pv=%b top=%h cnt=%0d, expected 22 1 AA 2", data_out, pop_valid, top, count);
    end
    do_op(1'b0, 1'b1, 1'b0, 8'h33);
    do_op(1'b0, 1'b1, 1'b0, 8'h44);
    do_op(1'b0, 1'b1, 1'b1, 8'hBB);
    n_checks++;
    if (data_out !== 8'h44 || pop_valid !== 1'b1 || top !== 8'hBB || count !== 3'd4 ||
        overflow !== 1'b0 || full !== 1'b1) begin
      n_fail++;
      $display("FAIL swap_full: dout=%h pv=%b top=%h cnt=%0d ovf=%b full=%b, expected 44 1 BB 4 0 1",
               data_out, pop_valid, top, count, overflow, full);
    end
  endtask

  task automatic test_swap_empty();
    do_op(1'b1, 1'b0, 1'b0, '0);
    do_op(1'b0, 1'b1, 1'b1, 8'h5A);
    n_checks++;
    if (data_out !== 8'h5A || pop_valid !== 1'b1 || count !== 3'd0 || empty !== 1'b1 ||
        overflow !== 1'b0 || underflow !== 1'b0 || top !== 8'h00) begin
      n_fail++;
      $display("FAIL swap_empty: dout=%h pv=%b cnt=%0d empty=%b ovf=%b udf=%b top=%h, expected 5A 1 0 1 0 0 00",
               data_out, pop_valid, count, empty, overflow, underflow, top);
    end
  endtask

  task automatic test_reset_mid();
    do_op(1'b0, 1'b1, 1'b0, 8'hC1);
    do_op(1'b0, 1'b1, 1'b0, 8'hC2);
    do_op(1'b0, 1'b1, 1'b0, 8'hC3);
    do_op(1'b0, 1'b0, 1'b1, '0);
    do_op(1'b0, 1'b1, 1'b0, 8'hC4);
    n_checks++;
    if (count !== 3'd3) begin
      n_fail++;
      $display("FAIL reset_mid_pre: cnt=%0d, expected 3", count);
    end
    do_op(1'b1, 1'b1, 1'b0, 8'hC5);
    n_checks++;
    if (count !== 3'd0 || empty !== 1'b1 || top !== 8'h00 || data_out !== 8'h00 ||
        pop_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: cnt=%0d empty=%b top=%h dout=%h pv=%b ovf=%b udf=%b, expected 0 1 00 00 0 0 0",
               count, empty, top, data_out, pop_valid, overflow, underflow);
    end
    do_op(1'b0, 1'b0, 1'b1, '0);
    n_checks++;
    if (underflow !== 1'b1 || pop_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_pop: udf=%b pv=%b, expected udf=1 pv=0", underflow, pop_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic p, q;
    do_op(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 300; i++) begin
      p = ($urandom_range(0, 99) < 55);
      q = ($urandom_range(0, 99) < 45);
      do_op(1'b0, p, q, DATA_W'($urandom));
      n_checks++;
      if (count !== CNT_W'(m_cnt) || top !== m_top() || full !== (m_cnt == DEPTH) ||
          empty !== (m_cnt == 0) || overflow !== m_ovf || underflow !== m_udf) begin
        n_fail++;
        $display("FAIL b2b[%0d]: cnt=%0d top=%h full=%b empty=%b ovf=%b udf=%b, expected cnt=%0d top=%h ovf=%b udf=%b",
                 i, count, top, full, empty, overflow, underflow, m_cnt, m_top(), m_ovf, m_udf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_push_fill();
    test_overflow_drain();
    test_underflow();
    test_swap();
    test_swap_empty();
    test_reset_mid();
    test_back_to_back();
    do_op(1'b0, 1'b0, 1'b0, '0);
    #10;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
